// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore FSM plus ALU decoder that sequences a multi-cycle RISC-V datapath
// (PC, instruction register, shared memory, register file, ALU, immediate
// generator). Every control output is combinational from the state register,
// op, funct3, funct7b5 and zero. Write enables are held low while reset is high.
//
// Build option: define MC_ILLEGAL_TRAP_EN to send unsupported opcodes and
// unused state codes to a sticky TRAP state and to add the `illegal` output.
// Without it, unsupported opcodes complete as a 2-cycle no-op.

module multicycle_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               zero,
   output logic               pcWrite,
   output logic               adrSrc,
   output logic               irWrite,
   output logic               memWrite,
   output logic               regWrite,
   output logic [1:0]         resultSrc,
   output logic [1:0]         aluSrcA,
   output logic [1:0]         aluSrcB,
   output logic [2:0]         aluControl,
   output logic [1:0]         immSrc,
   output logic [STATE_W-1:0] state
`ifdef MC_ILLEGAL_TRAP_EN
   ,
   output logic               illegal
`endif
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(0),
      S_DECODE   = STATE_W'(1),
      S_MEMADR   = STATE_W'(2),
      S_MEMREAD  = STATE_W'(3),
      S_MEMWB    = STATE_W'(4),
      S_MEMWRITE = STATE_W'(5),
      S_EXECUTER = STATE_W'(6),
      S_ALUWB    = STATE_W'(7),
      S_EXECUTEI = STATE_W'(8),
      S_JAL      = STATE_W'(9),
      S_BEQ      = STATE_W'(10)
`ifdef MC_ILLEGAL_TRAP_EN
      ,
      S_TRAP     = STATE_W'(11)
`endif
   } state_t;

   state_t     r_state;
   logic [1:0] w_alu_op;
   logic       w_pc_update;
   logic       w_branch;
   logic       w_ir_write;
   logic       w_mem_write;
   logic       w_reg_write;

   // State register: sequences each instruction through its 3-5 cycle path.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:    r_state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: r_state <= S_MEMADR;
                  OP_R:         r_state <= S_EXECUTER;
                  OP_I:         r_state <= S_EXECUTEI;
                  OP_JAL:       r_state <= S_JAL;
                  OP_BEQ:       r_state <= S_BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
                  default:      r_state <= S_TRAP;
`else
                  default:      r_state <= S_FETCH;
`endif
               endcase
            end
            S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  r_state <= S_MEMWB;
            S_MEMWB:    r_state <= S_FETCH;
            S_MEMWRITE: r_state <= S_FETCH;
            S_EXECUTER: r_state <= S_ALUWB;
            S_EXECUTEI: r_state <= S_ALUWB;
            S_JAL:      r_state <= S_ALUWB;
            S_ALUWB:    r_state <= S_FETCH;
            S_BEQ:      r_state <= S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:     r_state <= S_TRAP;
            default:    r_state <= S_TRAP;
`else
            default:    r_state <= S_FETCH;
`endif
         endcase
      end
   end

   // Per-state Moore decode of datapath selects and raw enables.
   always_comb begin
      // NOTE: every signal gets a default first so no latch is inferred.
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
      w_ir_write  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      w_alu_op    = 2'b00;
      adrSrc      = 1'b0;
      resultSrc   = 2'b00;
      aluSrcA     = 2'b00;
      aluSrcB     = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_ir_write  = 1'b1;
            aluSrcB     = 2'b10;
            resultSrc   = 2'b10;
            w_pc_update = 1'b1;
         end
         S_DECODE: begin
            aluSrcA = 2'b01;
            aluSrcB = 2'b01;
         end
         S_MEMADR: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b01;
         end
         S_MEMREAD:  adrSrc = 1'b1;
         S_MEMWB: begin
            resultSrc   = 2'b01;
            w_reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            adrSrc      = 1'b1;
            w_mem_write = 1'b1;
         end
         S_EXECUTER: begin
            aluSrcA  = 2'b10;
            w_alu_op = 2'b10;
         end
         S_EXECUTEI: begin
            aluSrcA  = 2'b10;
            aluSrcB  = 2'b01;
            w_alu_op = 2'b10;
         end
         S_ALUWB:    w_reg_write = 1'b1;
         S_BEQ: begin
            aluSrcA  = 2'b10;
            w_alu_op = 2'b01;
            w_branch = 1'b1;
         end
         S_JAL: begin
            aluSrcA     = 2'b01;
            aluSrcB     = 2'b10;
            w_pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU decoder: maps aluOp and the instruction function fields to an ALU operation.
   always_comb begin
      aluControl = 3'b000;
      case (w_alu_op)
         2'b00: aluControl = 3'b000;
         2'b01: aluControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  aluControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  aluControl = 3'b101;
               3'b110:  aluControl = 3'b011;
               3'b111:  aluControl = 3'b010;
               default: aluControl = 3'b000;
            endcase
         end
         default: aluControl = 3'b000;
      endcase
   end

   // Immediate format select, decoded from op in every state.
   always_comb begin
      case (op)
         OP_SW:   immSrc = 2'b01;
         OP_BEQ:  immSrc = 2'b10;
         OP_JAL:  immSrc = 2'b11;
         default: immSrc = 2'b00;
      endcase
   end

   // Write enables are suppressed while reset is held so nothing is clobbered.
   assign pcWrite  = ~reset & (w_pc_update | (w_branch & zero));
   assign irWrite  = ~reset & w_ir_write;
   assign memWrite = ~reset & w_mem_write;
   assign regWrite = ~reset & w_reg_write;
   assign state    = r_state;

`ifdef MC_ILLEGAL_TRAP_EN
   assign illegal  = ~reset & (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed instructions followed by
// random instruction streams, each compared cycle by cycle with an
// instruction-level reference model (expected state path and control
// outputs per step of each instruction class).

module tb_multicycle_controller;

   typedef enum int {C_LW, C_SW, C_R, C_I, C_JAL, C_BEQ, C_BAD} cls_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       pcWrite, adrSrc, irWrite, memWrite, regWrite;
   logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
   logic [2:0] aluControl;
   logic [3:0] state;
`ifdef MC_ILLEGAL_TRAP_EN
   logic       illegal;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
      .pcWrite    (pcWrite),
      .adrSrc     (adrSrc),
      .irWrite    (irWrite),
      .memWrite   (memWrite),
      .regWrite   (regWrite),
      .resultSrc  (resultSrc),
      .aluSrcA    (aluSrcA),
      .aluSrcB    (aluSrcB),
      .aluControl (aluControl),
      .immSrc     (immSrc),
      .state      (state)
`ifdef MC_ILLEGAL_TRAP_EN
      ,
      .illegal    (illegal)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   function automatic cls_t classify(input logic [6:0] o);
      case (o)
         7'b0000011: return C_LW;
         7'b0100011: return C_SW;
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b1101111: return C_JAL;
         7'b1100011: return C_BEQ;
         default:    return C_BAD;
      endcase
   endfunction

   // Expected state code at step k of an instruction of class c.
   function automatic int exp_state(input cls_t c, input int k);
      int lw_p[5]  = '{0, 1, 2, 3, 4};
      int sw_p[4]  = '{0, 1, 2, 5};
      int r_p[4]   = '{0, 1, 6, 7};
      int i_p[4]   = '{0, 1, 8, 7};
      int jal_p[4] = '{0, 1, 9, 7};
      int beq_p[3] = '{0, 1, 10};
      int bad_p[2] = '{0, 1};
      case (c)
         C_LW:    return lw_p[k];
         C_SW:    return sw_p[k];
         C_R:     return r_p[k];
         C_I:     return i_p[k];
         C_JAL:   return jal_p[k];
         C_BEQ:   return beq_p[k];
         default: return bad_p[k];
      endcase
   endfunction

   function automatic int n_steps(input cls_t c);
      case (c)
         C_LW:                    return 5;
         C_SW, C_R, C_I, C_JAL:   return 4;
         C_BEQ:                   return 3;
         default:                 return 2;
      endcase
   endfunction

   // ALU operation the instruction itself asks for in its execute step.
   function automatic int alu_expect(input cls_t c, input logic [2:0] f3, input logic f7);
      if (c == C_BEQ) return 1;
      case (f3)
         3'b000:  return (c == C_R && f7) ? 1 : 0;
         3'b010:  return 5;
         3'b110:  return 3;
         3'b111:  return 2;
         default: return 0;
      endcase
   endfunction

   // Runs one instruction (or its first max_steps cycles); zero_mode -1 = random.
   // Starts and ends just after a rising edge.
   task automatic run_instr(input logic [31:0] instr, input int max_steps, input int zero_mode);
      cls_t  c = classify(instr[6:0]);
      int    n;
      int    e_a, e_b, e_res, e_alu, e_imm;
      bit    e_ir, e_pc, e_mw, e_rw, e_adr;
      string nm;
      n  = n_steps(c);
      if (max_steps < n) n = max_steps;
      nm = c.name();
      for (int k = 0; k < n; k++) begin
         op       = instr[6:0];
         funct3   = instr[14:12];
         funct7b5 = instr[30];
         zero     = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
         @(negedge clk);
         e_ir  = (k == 0);
         e_pc  = (k == 0) || (c == C_JAL && k == 2) || (c == C_BEQ && k == 2 && zero);
         e_mw  = (c == C_SW && k == 3);
         e_rw  = (c == C_LW && k == 4) || ((c == C_R || c == C_I || c == C_JAL) && k == 3);
         e_adr = (c == C_LW || c == C_SW) && k == 3;
         e_res = (k == 0) ? 2 : ((c == C_LW && k == 4) ? 1 : 0);
         e_a   = 0;
         e_b   = 0;
         if (k == 0) e_b = 2;
         else if (k == 1) begin e_a = 1; e_b = 1; end
         else if (k == 2) begin
            case (c)
               C_LW, C_SW, C_I: begin e_a = 2; e_b = 1; end
               C_R, C_BEQ:      begin e_a = 2; e_b = 0; end
               C_JAL:           begin e_a = 1; e_b = 2; end
               default: ;
            endcase
         end
         e_alu = (k == 2 && (c == C_R || c == C_I || c == C_BEQ)) ?
                 alu_expect(c, instr[14:12], instr[30]) : 0;
         e_imm = (c == C_SW) ? 1 : (c == C_BEQ) ? 2 : (c == C_JAL) ? 3 : 0;
         check($sformatf("%s k%0d state", nm, k),      32'(state),      32'(exp_state(c, k)));
         check($sformatf("%s k%0d irWrite", nm, k),    32'(irWrite),    32'(e_ir));
         check($sformatf("%s k%0d pcWrite", nm, k),    32'(pcWrite),    32'(e_pc));
         check($sformatf("%s k%0d memWrite", nm, k),   32'(memWrite),   32'(e_mw));
         check($sformatf("%s k%0d regWrite", nm, k),   32'(regWrite),   32'(e_rw));
         check($sformatf("%s k%0d adrSrc", nm, k),     32'(adrSrc),     32'(e_adr));
         check($sformatf("%s k%0d resultSrc", nm, k),  32'(resultSrc),  32'(e_res));
         check($sformatf("%s k%0d aluSrcA", nm, k),    32'(aluSrcA),    32'(e_a));
         check($sformatf("%s k%0d aluSrcB", nm, k),    32'(aluSrcB),    32'(e_b));
         check($sformatf("%s k%0d aluControl", nm, k), 32'(aluControl), 32'(e_alu));
         check($sformatf("%s k%0d immSrc", nm, k),     32'(immSrc),     32'(e_imm));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " state"},    32'(state),    32'd0);
      check({tag, " irWrite"},  32'(irWrite),  32'd0);
      check({tag, " pcWrite"},  32'(pcWrite),  32'd0);
      check({tag, " memWrite"}, 32'(memWrite), 32'd0);
      check({tag, " regWrite"}, 32'(regWrite), 32'd0);
      check({tag, " aluSrcB"},  32'(aluSrcB),  32'd2);
   endtask

   logic [31:0] rnd_instr;
   logic [6:0]  op_tab[6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                              7'b0010011, 7'b1101111, 7'b1100011};

   initial begin
      // Reset held for three cycles
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_reset_outputs($sformatf("reset c%0d", i));
      end
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Directed instructions
      run_instr(32'hFFC4A303, 99, -1);   // lw
      run_instr(32'h0064A423, 99, -1);   // sw
      run_instr(32'h0062E233, 99, -1);   // or
      run_instr(32'h40628233, 99, -1);   // sub
      run_instr(32'h0062A233, 99, -1);   // slt
      run_instr(32'h00628233, 99, -1);   // add
      run_instr(32'hFE420AE3, 99, 1);    // beq taken
      run_instr(32'hFE420AE3, 99, 0);    // beq not taken
      run_instr(32'h008000EF, 99, -1);   // jal
`ifndef MC_ILLEGAL_TRAP_EN
      run_instr(32'h00000000, 99, -1);   // unsupported op: 2-cycle no-op
`endif

      // Reset asserted mid-instruction (lw abandoned in MEMREAD)
      run_instr(32'hFFC4A303, 3, -1);
      reset = 1'b1;
      #1;
      check_reset_outputs("midrst async");
      @(posedge clk);
      #1;
      check_reset_outputs("midrst held");
      reset = 1'b0;
      run_instr(32'h0064A423, 99, -1);

      // Random instruction stream
      for (int i = 0; i < 400; i++) begin
         int sel = $urandom_range(0, 6);
         rnd_instr = $urandom;
         if (sel < 6) rnd_instr[6:0] = op_tab[sel];
         else if (classify(rnd_instr[6:0]) != C_BAD) rnd_instr[6:0] = 7'b0000000;
`ifdef MC_ILLEGAL_TRAP_EN
         if (classify(rnd_instr[6:0]) == C_BAD) rnd_instr[6:0] = 7'b0010011;
`endif
         run_instr(rnd_instr, 99, -1);
      end

`ifdef MC_ILLEGAL_TRAP_EN
      // Unsupported op traps until reset
      run_instr(32'h00000000, 99, -1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("trap state",    32'(state),    32'd11);
         check("trap illegal",  32'(illegal),  32'd1);
         check("trap pcWrite",  32'(pcWrite),  32'd0);
         check("trap irWrite",  32'(irWrite),  32'd0);
         check("trap regWrite", 32'(regWrite), 32'd0);
         check("trap memWrite", 32'(memWrite), 32'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("trap rst illegal", 32'(illegal), 32'd0);
      check_reset_outputs("trap rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      run_instr(32'h008000EF, 99, -1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM plus ALU decoder that sequences the multi-cycle RISC-V datapath: PC, instruction register, shared memory, register file, ALU and immediate generator.
- Each instruction takes 3-5 cycles.
- Drives `immSrc` to the immediate generator, so the sign-extended immediate is valid by DECODE.
- Sits beside the datapath. All control outputs are combinational from `state`, `op`, `funct3`, `funct7b5` and `zero`.

Parameters:
- `STATE_W`, default 4: width of the `state` debug output and the state register.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `op` input 7: `instr[6:0]` from the instruction register.
- `funct3` input 3: `instr[14:12]`.
- `funct7b5` input 1: `instr[30]`.
- `zero` input 1: ALU zero flag.
- `pcWrite` output 1: PC register enable.
- `adrSrc` output 1: memory address select; 0 = PC, 1 = ALU result register.
- `irWrite` output 1: instruction register and oldPC enable.
- `memWrite` output 1: data memory write strobe.
- `regWrite` output 1: register file write enable.
- `resultSrc` output 2: result mux; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `aluSrcA` output 2: ALU A select; 00 = PC, 01 = oldPC, 10 = rs1 register.
- `aluSrcB` output 2: ALU B select; 00 = rs2 register, 01 = immExt, 10 = constant 4.
- `aluControl` output 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `immSrc` output 2: 00 I, 01 S, 10 B, 11 J.
- `state` output STATE_W: current state code, for debug.

Behaviour:
- State codes:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
  - EXECUTER = 6, ALUWB = 7, EXECUTEI = 8, JAL = 9, BEQ = 10, TRAP = 11
- Reset:
  - `reset` high drives `state` to FETCH asynchronously.
  - While `reset` is high, `pcWrite`, `irWrite`, `memWrite` and `regWrite` are forced to 0.
  - The mux selects and `aluControl` show their FETCH values while `reset` is high.
  - Assertion mid-instruction abandons that instruction. The first cycle after deassertion is FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR on `op` 0000011 (lw) or 0100011 (sw).
  - DECODE -> EXECUTER on 0110011, EXECUTEI on 0010011, JAL on 1101111, BEQ on 1100011.
  - DECODE -> FETCH on any other `op`.
  - MEMADR -> MEMREAD if lw, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER, EXECUTEI and JAL -> ALUWB -> FETCH.
  - BEQ -> FETCH.
  - Unused codes -> FETCH.
- Per-state outputs; unlisted signals are 0, and `aluOp` is internal:
  - FETCH: `irWrite` = 1, `aluSrcB` = 10, `resultSrc` = 10, `pcUpdate` = 1, `aluOp` = 00.
  - DECODE: `aluSrcA` = 01, `aluSrcB` = 01, `aluOp` = 00 (branch target).
  - MEMADR: `aluSrcA` = 10, `aluSrcB` = 01, `aluOp` = 00.
  - MEMREAD: `adrSrc` = 1.
  - MEMWB: `resultSrc` = 01, `regWrite` = 1.
  - MEMWRITE: `adrSrc` = 1, `memWrite` = 1.
  - EXECUTER: `aluSrcA` = 10, `aluOp` = 10.
  - EXECUTEI: `aluSrcA` = 10, `aluSrcB` = 01, `aluOp` = 10.
  - ALUWB: `regWrite` = 1.
  - BEQ: `aluSrcA` = 10, `aluOp` = 01, `branch` = 1.
  - JAL: `aluSrcA` = 01, `aluSrcB` = 10, `pcUpdate` = 1.
- `pcWrite` = `pcUpdate` | (`branch` & `zero`). `zero` is only sampled in BEQ.
- ALU decode:
  - `aluOp` 00 -> add; 01 -> sub.
  - `aluOp` 10 with `funct3` 000 -> sub if `op[5]` & `funct7b5`, else add.
  - `aluOp` 10 with `funct3` 010 -> slt, 110 -> or, 111 -> and.
  - `aluOp` 10 with any other `funct3` -> add.
- `immSrc`: combinational from `op` in every state.
  - 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; all other `op` -> 00.
- Latency:
  - lw: 5 cycles.
  - sw, R-type, I-type ALU, jal: 4 cycles.
  - beq: 3 cycles.
  - Unsupported `op`: 2 cycles without the optional feature.

Optional Feature:
- Macro: `MC_ILLEGAL_TRAP_EN`.
- Defined:
  - An unsupported `op` in DECODE -> TRAP.
  - TRAP holds, with all enables 0, until `reset`.
  - Adds output `illegal` (1 bit): 1 only while in TRAP, 0 on reset.
  - Unused state codes also go to TRAP.
- Undefined: no TRAP state and no `illegal` port. An unsupported `op` returns DECODE -> FETCH and executes as a 2-cycle no-op.

Test Plan:
- Reset held for 3 cycles, then released:
  - `state` = 0 throughout reset.
  - `irWrite`, `pcWrite`, `memWrite`, `regWrite` = 0 during reset.
  - First cycle after release: `irWrite` = 1, `pcWrite` = 1, `aluSrcB` = 10.
- lw 0xFFC4A303:
  - States 0, 1, 2, 3, 4, then 0; `immSrc` = 00.
  - `adrSrc` = 1 only in state 3.
  - `regWrite` = 1 with `resultSrc` = 01 only in state 4.
- sw 0x0064A423:
  - States 0, 1, 2, 5, 0; `immSrc` = 01.
  - `memWrite` = 1 for exactly one cycle, in state 5.
  - `regWrite` never asserts.
- R-type, with `aluControl` checked in EXECUTER:
  - or 0x0062E233 -> `aluControl` = 011.
  - sub 0x40628233 -> `aluControl` = 001.
  - slt 0x0062A233 -> `aluControl` = 101.
  - add 0x00628233 -> `aluControl` = 000.
  - Each then passes through ALUWB with `regWrite` = 1.
- beq 0xFE420AE3 (`immSrc` = 10 in DECODE):
  - `zero` = 1 -> `pcWrite` = 1 in BEQ.
  - `zero` = 0 -> `pcWrite` = 0.
  - Both cases return to FETCH after 3 cycles.
- jal 0x008000EF, then `op` 0000000:
  - jal: `immSrc` = 11; states 0, 1, 9, 7, 0; `pcWrite` = 1 in JAL.
  - `op` 0000000, macro undefined: states 0, 1, 0.
  - `op` 0000000, macro defined: `state` = 11 held, `illegal` = 1, until reset.
